// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: aligned word access to a byte-enable-free RAM,
// read-modify-write for sub-word stores, lane extraction with sign/zero extension for loads.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_sign_mask,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StRsp
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         word_q, word_d;
    logic [3:0]          sm_q, sm_d;
    logic                write_q, write_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                mis_q, mis_d;

    logic                req_mis;
    logic                is_byte, is_half;
    logic [4:0]          shamt;
    logic [31:0]         lane_data;
    logic [31:0]         lane_mask;
    logic [31:0]         load_val;
    logic [31:0]         merged;

    // Address bits above the RAM word range are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    // Illegal size codes are rejected along with true misalignment.
    always_comb begin
        req_mis = 1'b1;
        unique case (req_sign_mask[2:0])
            3'b001:  req_mis = 1'b0;
            3'b011:  req_mis = req_addr[0];
            3'b111:  req_mis = |req_addr[1:0];
            default: req_mis = 1'b1;
        endcase
    end

    assign is_byte   = (sm_q[2:0] == 3'b001);
    assign is_half   = (sm_q[2:0] == 3'b011);
    assign shamt     = {addr_q[1:0], 3'b000};
    assign lane_data = mem_rdata >> shamt;
    assign lane_mask = (is_byte ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
    assign merged    = (mem_rdata & ~lane_mask) | ((word_q << shamt) & lane_mask);

    always_comb begin
        load_val = mem_rdata;
        if (is_byte) begin
            load_val = {{24{sm_q[3] & lane_data[7]}}, lane_data[7:0]};
        end else if (is_half) begin
            load_val = {{16{sm_q[3] & lane_data[15]}}, lane_data[15:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        sm_d    = sm_q;
        write_d = write_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr[ADDR_W+1:0];
                    word_d  = req_wdata;
                    sm_d    = req_sign_mask;
                    write_d = req_write;
                    rdata_d = 32'h0;
                    mis_d   = req_mis;
                    if (req_mis) begin
                        state_d = StRsp;
                    end else if (req_write && req_sign_mask[2:0] == 3'b111) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: state_d = StCap;
            StCap: begin
                if (write_q) begin
                    word_d  = merged;
                    state_d = StWr;
                end else begin
                    rdata_d = load_val;
                    state_d = StRsp;
                end
            end
            StWr:    state_d = StRsp;
            StRsp:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            word_q  <= '0;
            sm_q    <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            sm_q    <= sm_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Strobes decode straight from the state register so reset kills them at once.
    assign req_ready      = (state_q == StIdle);
    assign mem_re         = (state_q == StRd);
    assign mem_we         = (state_q == StWr);
    assign rsp_valid      = (state_q == StRsp);
    assign mem_addr       = addr_q[ADDR_W+1:2];
    assign mem_wdata      = word_q;
    assign rsp_rdata      = rdata_q;
    assign rsp_misaligned = mis_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a behavioural synchronous RAM.
module tb_dmem_access_ctrl;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_write;
    logic [31:0]       req_addr, req_wdata;
    logic [3:0]        req_sign_mask;
    logic              rsp_valid, rsp_misaligned;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re, mem_we;
    logic [31:0]       mem_wdata, mem_rdata;

    logic [31:0]       ram [0:(1<<ADDR_W)-1];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [31:0]       pre_data = '0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          rsp_lat;
        int          re_lat;
        int          we_lat;
        logic [31:0] waddr;
        logic [31:0] wword;
    } item_t;

    item_t q[$];
    int    acc_hist[$];
    int    n_total = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    acc = 0;
    int    re_at = -1;
    int    we_at = -1;
    int    we_cnt = 0;
    int    rsp_cnt = 0;

    dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_sign_mask  (req_sign_mask),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .mem_addr       (mem_addr),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic item_t mk(input logic [31:0] rdata, input logic mis, input int rsp_lat,
                                 input int re_lat, input int we_lat, input logic [31:0] waddr,
                                 input logic [31:0] wword);
        item_t e;
        e.rdata = rdata; e.mis = mis; e.rsp_lat = rsp_lat; e.re_lat = re_lat;
        e.we_lat = we_lat; e.waddr = waddr; e.wword = wword;
        return e;
    endfunction

    // Monitor: samples on the falling edge, pops the scoreboard on each response.
    always @(negedge clk) begin
        item_t e;
        if (req_valid && req_ready) begin
            acc   = cyc;
            re_at = -1;
            we_at = -1;
            acc_hist.push_back(cyc);
        end
        if (mem_re || mem_we) check_eq("re_we_exclusive", 32'(mem_re & mem_we), 32'h0);
        if (mem_re) begin
            if (re_at < 0) re_at = cyc - acc;
            if (q.size() > 0) check_eq("rd_mem_addr", 32'(mem_addr), q[0].waddr);
        end
        if (mem_we) begin
            we_cnt++;
            if (we_at < 0) we_at = cyc - acc;
            if (q.size() > 0) check_eq("wr_mem_wdata", mem_wdata, q[0].wword);
        end
        if (rsp_valid) begin
            rsp_cnt++;
            if (q.size() == 0) begin
                check_eq("unexpected_rsp", 32'h1, 32'h0);
            end else begin
                e = q.pop_front();
                check_eq("rsp_latency", 32'(cyc - acc), 32'(e.rsp_lat));
                check_eq("rsp_rdata", rsp_rdata, e.rdata);
                check_eq("rsp_misaligned", 32'(rsp_misaligned), 32'(e.mis));
                check_eq("re_latency", 32'(re_at), 32'(e.re_lat));
                check_eq("we_latency", 32'(we_at), 32'(e.we_lat));
            end
        end
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] sm);
        @(posedge clk);
        #1;
        req_write = w; req_addr = a; req_wdata = wd; req_sign_mask = sm; req_valid = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check_eq("rsp_timeout", 32'(q.size()), 32'h0);
            q.delete();
        end
    endtask

    task automatic run(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] sm, input item_t e);
        int n = 0;
        q.push_back(e);
        drive(w, a, wd, sm);
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_eq("accept_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();
    endtask

    initial begin
        int w0, r0, h0, n;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_sign_mask = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_req_ready", 32'(req_ready), 32'h1);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("reset_mem_strobes", 32'({mem_re, mem_we}), 32'h0);
        check_eq("reset_rsp_rdata", rsp_rdata, 32'h0);

        preload(10'd4, 32'h80FF_7F01);
        // Loads
        run(1'b0, 32'h13, 32'h0, 4'b1001, mk(32'hFFFF_FF80, 1'b0, 3, 1, -1, 32'd4, 32'h0));
        run(1'b0, 32'h13, 32'h0, 4'b0001, mk(32'h0000_0080, 1'b0, 3, 1, -1, 32'd4, 32'h0));
        run(1'b0, 32'h12, 32'h0, 4'b1011, mk(32'hFFFF_80FF, 1'b0, 3, 1, -1, 32'd4, 32'h0));
        run(1'b0, 32'h10, 32'h0, 4'b0011, mk(32'h0000_7F01, 1'b0, 3, 1, -1, 32'd4, 32'h0));
        run(1'b0, 32'h10, 32'h0, 4'b1111, mk(32'h80FF_7F01, 1'b0, 3, 1, -1, 32'd4, 32'h0));
        run(1'b0, 32'h11, 32'h0, 4'b1001, mk(32'h0000_007F, 1'b0, 3, 1, -1, 32'd4, 32'h0));
        run(1'b0, 32'hFFFF_F013, 32'h0, 4'b1001,
            mk(32'hFFFF_FF80, 1'b0, 3, 1, -1, 32'd4, 32'h0));

        // Sub-word stores
        run(1'b1, 32'h11, 32'h1234_56AA, 4'b1001,
            mk(32'h0, 1'b0, 4, 1, 3, 32'd4, 32'h80FF_AA01));
        check_eq("ram_after_byte", ram[4], 32'h80FF_AA01);
        preload(10'd4, 32'h80FF_7F01);
        run(1'b1, 32'h12, 32'hDEAD_BEEF, 4'b0011,
            mk(32'h0, 1'b0, 4, 1, 3, 32'd4, 32'hBEEF_7F01));
        check_eq("ram_after_half", ram[4], 32'hBEEF_7F01);

        // Word store then read back
        run(1'b1, 32'h10, 32'hCAFE_F00D, 4'b0111, mk(32'h0, 1'b0, 2, -1, 1, 32'd4, 32'hCAFE_F00D));
        run(1'b0, 32'h10, 32'h0, 4'b1111, mk(32'hCAFE_F00D, 1'b0, 3, 1, -1, 32'd4, 32'h0));

        // Misaligned and empty-mask requests
        run(1'b0, 32'h12, 32'h0, 4'b0111, mk(32'h0, 1'b1, 1, -1, -1, 32'd4, 32'h0));
        run(1'b0, 32'h11, 32'h0, 4'b1011, mk(32'h0, 1'b1, 1, -1, -1, 32'd4, 32'h0));
        run(1'b1, 32'h10, 32'h5555_5555, 4'b1000, mk(32'h0, 1'b1, 1, -1, -1, 32'd4, 32'h0));
        check_eq("ram_after_misaligned", ram[4], 32'hCAFE_F00D);

        // Reset during CAP of a byte store
        preload(10'd4, 32'h80FF_7F01);
        w0 = we_cnt;
        r0 = rsp_cnt;
        drive(1'b1, 32'h11, 32'h1234_56AA, 4'b0001);
        @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async_we", 32'(mem_we), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("rst_no_we", 32'(we_cnt), 32'(w0));
        check_eq("rst_no_rsp", 32'(rsp_cnt), 32'(r0));
        check_eq("rst_ram_kept", ram[4], 32'h80FF_7F01);
        check_eq("rst_req_ready", 32'(req_ready), 32'h1);

        // Request held across a busy access: one access per acceptance, no extra bubble
        h0 = acc_hist.size();
        q.push_back(mk(32'h80FF_7F01, 1'b0, 3, 1, -1, 32'd4, 32'h0));
        q.push_back(mk(32'h80FF_7F01, 1'b0, 3, 1, -1, 32'd4, 32'h0));
        drive(1'b0, 32'h10, 32'h0, 4'b0111);
        n = 0;
        while (acc_hist.size() < h0 + 2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        check_eq("b2b_accepts", 32'(acc_hist.size() - h0), 32'h2);
        if (acc_hist.size() >= h0 + 2) begin
            check_eq("b2b_gap", 32'(acc_hist[h0+1] - acc_hist[h0]), 32'h4);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Data-memory side consumer of the load/store {sign, mask} code (bit3 = sign-extend, bits[2:0] = 001 byte / 011 half / 111 word).
- Sits between the core's memory stage and a word-wide, single-port synchronous data RAM with no byte enables.
- Performs aligned word accesses, read-modify-write for sub-word stores, and lane extraction with sign/zero extension for sub-word loads.
- Provides a valid/ready request handshake and a one-cycle response pulse for stalling the core.

Parameters:
- ADDR_W, 10, word-address width of the RAM (2^ADDR_W 32-bit words); req_addr bits above ADDR_W+1 are ignored.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present; requester holds all req_* stable until accepted.
- req_ready  output  1  high only in IDLE; a request is accepted on a cycle with req_valid & req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the operand occupies the low bits.
- req_sign_mask  input  4  {sign, mask[2:0]} load/store size code.
- rsp_valid  output  1  one-cycle pulse when the access completes.
- rsp_rdata  output  32  extended load data; valid with rsp_valid for loads, 0 for stores.
- rsp_misaligned  output  1  valid with rsp_valid; access rejected, no RAM activity.
- mem_addr  output  ADDR_W  RAM word address = latched req_addr[ADDR_W+1:2].
- mem_re  output  1  RAM read strobe; data appears on mem_rdata the following cycle.
- mem_we  output  1  RAM write strobe, full 32-bit word.
- mem_wdata  output  32  RAM write word.
- mem_rdata  input  32  RAM read word.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - All outputs registered and cleared to 0, except req_ready, which is 1 in IDLE.
  - Reset mid-operation aborts immediately: mem_we/mem_re drop asynchronously, no partial write completes, and no rsp_valid is issued.
- States: IDLE, RD, CAP, WR, RSP.
- IDLE:
  - Accepts a request and latches addr, wdata, sign_mask and write.
  - Misaligned cases: mask 000; half with addr[0]=1; word with addr[1:0]!=0. These go to RSP with misaligned=1.
  - Otherwise: word store goes to WR; every load and every sub-word store goes to RD.
- RD: mem_re=1, mem_addr valid; next state CAP.
- CAP: mem_rdata is sampled.
  - Load: rdata <= extract(mem_rdata), then RSP.
  - Sub-word store: merged word <= mem_rdata with the selected lane(s) replaced, then WR.
- WR: mem_we=1, mem_wdata = merged word, or latched wdata for a word store; next state RSP.
- RSP: rsp_valid=1 for exactly one cycle; next state IDLE (req_ready=1 the following cycle).
- Extraction:
  - Byte lane b = addr[1:0], value = mem_rdata[8b+7:8b]; half lane h = addr[1], value = mem_rdata[16h+15:16h].
  - If sign=1, fill bits 31 down to the operand width with the operand MSB; otherwise fill with 0.
  - Word loads ignore the sign bit.
- Merge:
  - Byte: req_wdata[7:0] into lane b.
  - Half: req_wdata[15:0] into lane h.
  - All other RAM bits are preserved.
- Latency, with acceptance at cycle 0:
  - Load: rsp_valid at cycle 3.
  - Word store: mem_we at cycle 1, rsp_valid at cycle 2.
  - Sub-word store: mem_re at cycle 1, mem_we at cycle 3, rsp_valid at cycle 4.
  - Misaligned: rsp_valid at cycle 1.
- Sign bit on stores is ignored.
- mem_re and mem_we are never high in the same cycle.
- req_valid while not IDLE is ignored, not queued.
- Back-to-back: a request held through RSP is accepted in the first IDLE cycle after it. There is no bubble beyond the RSP→IDLE cycle.

Test Plan:
- Preload mem[4]=0x80FF7F01. Load addr 0x13, mask 1001 -> rsp_rdata 0xFFFFFF80 at cycle 3. Repeat with mask 0001 -> 0x00000080. mem_addr=4 in RD.
- Loads: addr 0x12, mask 1011 -> 0xFFFF80FF; addr 0x10, mask 0011 -> 0x00007F01; addr 0x10, mask 1111 -> 0x80FF7F01.
- Store byte: addr 0x11, wdata 0x123456AA, mask x001 -> mem_we at cycle 3 with mem_wdata 0x80FFAA01. Store half: addr 0x12, wdata 0xDEADBEEF -> 0xBEEF7F01.
- Store word: addr 0x10, wdata 0xCAFEF00D -> mem_we at cycle 1, mem_re never asserted, rsp_valid at cycle 2. A subsequent load word at 0x10 returns 0xCAFEF00D.
- Misaligned: word at 0x12, half at 0x11, mask 000 -> rsp_valid at cycle 1 with rsp_misaligned=1, and no mem_re/mem_we.
- Reset: assert rst_n=0 during CAP of a sub-word store -> mem_we never pulses, mem[4] unchanged, and req_ready=1 after release. Separately, req_valid held high during a busy access -> exactly one access per acceptance.
